// File: rtl/crank_decoder_pkg.sv
// Shared types and constants for the crank/cam position decoder.
package crank_decoder_pkg;

  localparam int TOOTH_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_SYNCED  = 2'd3
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse (one clk wide).
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchronizer chain and edge register
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/crank_cam_decoder.sv
// Missing-tooth crank wheel decoder with cam phase qualification: tracks tooth
// index, 720-degree phase, tooth period and stall.
module crank_cam_decoder
  import crank_decoder_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int CRANK_TEETH       = 58,
  parameter int CRANK_TEETH_TOTAL = 60,
  parameter int STALL_CYCLES      = 2**24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   crank,
  input  logic                   cam,
  output logic                   sync,
  output logic [TOOTH_IDX_W-1:0] tooth_idx,
  output logic                   phase,
  output logic                   cam_valid,
  output logic                   tooth_strobe,
  output logic [DATA_WIDTH-1:0]  tooth_period,
  output logic                   sync_err
);

  if (CRANK_TEETH_TOTAL <= CRANK_TEETH || CRANK_TEETH_TOTAL > (1 << TOOTH_IDX_W)) begin : g_cfg_check
    $error("crank_cam_decoder: CRANK_TEETH_TOTAL must exceed CRANK_TEETH and fit tooth_idx");
  end

  localparam logic [TOOTH_IDX_W-1:0] IDX_LAST  = TOOTH_IDX_W'(CRANK_TEETH - 1);
  localparam logic [DATA_WIDTH-1:0]  STALL_CNT = DATA_WIDTH'(STALL_CYCLES);

  logic crank_rise_s, cam_rise_s, gap_s, stall_s, cam_hit_s;
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0]  cnt_q, prev_q, prev_d, per_q, per_d;
  logic [TOOTH_IDX_W-1:0] idx_q, idx_d;
  logic sync_q, sync_d, err_q, err_d, strobe_q, strobe_d;
  logic phase_q, phase_d, cv_q, cv_d, cam_seen_q, cam_seen_d, miss_q, miss_d;

  edge_sync u_crank_sync (.clk(clk), .rst(rst), .async_i(crank), .rise_o(crank_rise_s));
  edge_sync u_cam_sync   (.clk(clk), .rst(rst), .async_i(cam),   .rise_o(cam_rise_s));

  // Strict "more than twice the previous period", evaluated one bit wider
  assign gap_s     = ({1'b0, cnt_q} > {prev_q, 1'b0});
  assign stall_s   = ~crank_rise_s & (cnt_q == STALL_CNT);
  assign cam_hit_s = cam_seen_q | cam_rise_s;

  // Clocks since the last accepted crank edge, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (crank_rise_s) begin
      cnt_q <= DATA_WIDTH'(1);
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + DATA_WIDTH'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stall_s) begin
      state_d = ST_IDLE;
    end else if (crank_rise_s) begin
      case (state_q)
        ST_IDLE:    state_d = ST_MEASURE;
        ST_MEASURE: state_d = ST_SEARCH;
        ST_SEARCH:  state_d = gap_s ? ST_SYNCED : ST_SEARCH;
        ST_SYNCED:  state_d = (gap_s ? (idx_q != IDX_LAST) : (idx_q == IDX_LAST)) ? ST_SEARCH : ST_SYNCED;
        default:    state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output and datapath next values
  always_comb begin
    strobe_d   = crank_rise_s;
    err_d      = 1'b0;
    sync_d     = sync_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    cv_d       = cv_q;
    per_d      = per_q;
    prev_d     = prev_q;
    miss_d     = miss_q;
    cam_seen_d = cam_seen_q | cam_rise_s;
    if (stall_s) begin
      err_d  = (state_q == ST_SYNCED);
      sync_d = 1'b0;
      idx_d  = '0;
      cv_d   = 1'b0;
      per_d  = '0;
      prev_d = '0;
      miss_d = 1'b0;
    end else if (crank_rise_s) begin
      if (state_q == ST_MEASURE || ((state_q == ST_SEARCH || state_q == ST_SYNCED) && !gap_s)) begin
        prev_d = cnt_q;
        per_d  = cnt_q;
      end else begin
        prev_d = prev_q;
      end
      case (state_q)
        ST_SEARCH: begin
          if (gap_s) begin
            cam_seen_d = 1'b0;
            sync_d     = 1'b1;
            idx_d      = '0;
          end else begin
            sync_d = 1'b0;
          end
        end
        ST_SYNCED: begin
          if (gap_s && idx_q == IDX_LAST) begin
            // Valid revolution wrap; a cam edge landing on the gap still counts here
            cam_seen_d = 1'b0;
            idx_d      = '0;
            if (cam_hit_s) begin
              phase_d = 1'b0;
              cv_d    = 1'b1;
              miss_d  = 1'b0;
            end else begin
              phase_d = ~phase_q;
              miss_d  = 1'b1;
              cv_d    = miss_q ? 1'b0 : cv_q;
            end
          end else if (gap_s || idx_q == IDX_LAST) begin
            cam_seen_d = gap_s ? 1'b0 : cam_seen_d;
            err_d      = 1'b1;
            sync_d     = 1'b0;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + TOOTH_IDX_W'(1);
          end
        end
        default: begin
          sync_d = 1'b0;
        end
      endcase
    end else begin
      err_d = 1'b0;
    end
  end

  // Registered outputs and decoder state
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      sync_q     <= 1'b0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
      cv_q       <= 1'b0;
      per_q      <= '0;
      prev_q     <= '0;
      miss_q     <= 1'b0;
      cam_seen_q <= 1'b0;
    end else begin
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      sync_q     <= sync_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      cv_q       <= cv_d;
      per_q      <= per_d;
      prev_q     <= prev_d;
      miss_q     <= miss_d;
      cam_seen_q <= cam_seen_d;
    end
  end

  assign tooth_strobe = strobe_q;
  assign sync_err     = err_q;
  assign sync         = sync_q;
  assign tooth_idx    = idx_q;
  assign phase        = phase_q;
  assign cam_valid    = cv_q;
  assign tooth_period = per_q;

endmodule

// File: tb/tb_crank_cam_decoder.sv
// Scoreboard bench for crank_cam_decoder on a 60-2 wheel: expectations are
// queued as each tooth is driven and checked against every tooth_strobe.
module tb_crank_cam_decoder;

  logic        clk = 1'b0;
  logic        rst, crank, cam;
  logic        sync, phase, cam_valid, tooth_strobe, sync_err;
  logic [7:0]  tooth_idx;
  logic [31:0] tooth_period;

  crank_cam_decoder #(
    .DATA_WIDTH(32), .CRANK_TEETH(58), .CRANK_TEETH_TOTAL(60), .STALL_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .crank(crank), .cam(cam),
    .sync(sync), .tooth_idx(tooth_idx), .phase(phase), .cam_valid(cam_valid),
    .tooth_strobe(tooth_strobe), .tooth_period(tooth_period), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit sync;
    bit err;
    int idx;
    bit ph;
    bit cv;
    int per;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_strobe_cyc = 0;
  bit   stall_window = 1'b0;
  bit   ok;

  // Phase / cam_valid during revolutions 0..5 after first sync (cam in revs 0 and 2)
  bit rev_ph [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit rev_cv [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every strobe against the head of the scoreboard
  always @(negedge clk) begin
    if (tooth_strobe) begin
      checks++;
      last_strobe_cyc = cyc;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected cyc=%0d idx=%0d sync=%0d", cyc, tooth_idx, sync);
      end else begin
        e  = q.pop_front();
        ok = (cyc == e.cyc) && (sync == e.sync) && (sync_err == e.err);
        if (e.sync) ok = ok && (int'(tooth_idx) == e.idx) && (phase == e.ph) && (cam_valid == e.cv);
        if (e.per >= 0) ok = ok && (int'(tooth_period) == e.per);
        if (!ok) begin
          failures++;
          $display("FAIL strobe_check got cyc=%0d sync=%0d err=%0d idx=%0d ph=%0d cv=%0d per=%0d expected cyc=%0d sync=%0d err=%0d idx=%0d ph=%0d cv=%0d per=%0d",
                   cyc, sync, sync_err, tooth_idx, phase, cam_valid, tooth_period,
                   e.cyc, e.sync, e.err, e.idx, e.ph, e.cv, e.per);
        end
      end
    end else if (sync_err && !stall_window) begin
      checks++;
      failures++;
      $display("FAIL spurious_sync_err cyc=%0d got sync_err=1 expected 0", cyc);
    end
  end

  // One crank tooth: rise now, 10 clk high, next rise 'interval' clk later
  task automatic tooth(input int interval, input bit s, input bit er, input int idx,
                       input bit ph, input bit cv, input int per, input bit with_cam);
    exp_t x;
    x.cyc = cyc + 4;
    x.sync = s; x.err = er; x.idx = idx; x.ph = ph; x.cv = cv; x.per = per;
    q.push_back(x);
    crank = 1'b1;
    cam   = with_cam;
    repeat (10) @(negedge clk);
    crank = 1'b0;
    cam   = 1'b0;
    repeat (interval - 10) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (sync || tooth_idx != 8'd0 || phase || cam_valid || tooth_strobe ||
        tooth_period != 32'd0 || sync_err) begin
      failures++;
      $display("FAIL %s got sync=%0d idx=%0d ph=%0d cv=%0d strobe=%0d per=%0d err=%0d expected all 0",
               name, sync, tooth_idx, phase, cam_valid, tooth_strobe, tooth_period, sync_err);
    end
  endtask

  initial begin
    int delta;
    bit seen;
    crank = 1'b0; cam = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // Start mid-wheel: IDLE, MEASURE, SEARCH, then lock at the gap
    for (int p = 50; p < 58; p++) tooth((p == 57) ? 60 : 20, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0);

    // Five synced revolutions; cam at tooth 2 of revs 0 and 2 only
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < 58; p++)
        tooth((p == 57) ? 60 : 20, 1'b1, 1'b0, p, rev_ph[r], rev_cv[r], 20,
              (p == 2) && (r == 0 || r == 2));

    // Rev 5 carries only 57 teeth: early gap flags an error, resync one rev later
    for (int p = 0; p < 57; p++) tooth((p == 56) ? 60 : 20, 1'b1, 1'b0, p, rev_ph[5], rev_cv[5], 20, 1'b0);
    for (int p = 0; p < 58; p++) tooth((p == 57) ? 60 : 20, 1'b0, (p == 0), 0, 1'b0, 1'b0, -1, 1'b0);

    // Rev 7: accelerate from 40 to ~20 clk per tooth; no false gap
    for (int p = 0; p < 58; p++)
      tooth((p == 57) ? 60 : (40 - (20 * p) / 57), 1'b1, 1'b0, p, 1'b0, 1'b0, (p == 0) ? 20 : -1, 1'b0);

    // Rev 8 (phase toggled, cam never seen) up to tooth 30, then a one-clk reset
    for (int p = 0; p <= 30; p++) tooth(20, 1'b1, 1'b0, p, 1'b1, 1'b0, (p == 0) ? -1 : 20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrev_reset_outputs");
    rst = 1'b0;
    for (int p = 31; p < 58; p++) tooth((p == 57) ? 60 : 20, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 1'b0);
    for (int p = 0; p < 6; p++) tooth(20, 1'b1, 1'b0, p, 1'b0, 1'b0, 20, 1'b0);

    // Crank stops: stall must fire exactly 1000 clk after the last strobe
    stall_window = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (sync_err) seen = 1'b1;
    end
    delta = cyc - last_strobe_cyc;
    checks++;
    if (!seen || delta != 1000) begin
      failures++;
      $display("FAIL stall_timing got seen=%0d delay=%0d expected seen=1 delay=1000", seen, delta);
    end
    checks++;
    if (sync || tooth_period != 32'd0 || cam_valid) begin
      failures++;
      $display("FAIL stall_outputs got sync=%0d per=%0d cv=%0d expected 0 0 0", sync, tooth_period, cam_valid);
    end
    @(negedge clk);
    checks++;
    if (sync_err) begin
      failures++;
      $display("FAIL stall_err_width got sync_err=1 expected 0 one cycle later");
    end
    stall_window = 1'b0;

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL strobes_missing got pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
